// File: rtl/riscv_dbg_pkg.sv
// Shared DMI field layout, enums and request payload for the DTM-side dbus controller.
package riscv_dbg_pkg;

  localparam int unsigned DMI_W        = 41;
  localparam int unsigned DMI_RESP_W   = 36;
  localparam int unsigned DMI_ADDR_W   = 5;
  localparam int unsigned DMI_DATA_W   = 34;
  localparam int unsigned DMI_ADDR_MSB = 40;
  localparam int unsigned DMI_ADDR_LSB = 36;
  localparam int unsigned DMI_DATA_MSB = 35;
  localparam int unsigned DMI_DATA_LSB = 2;
  localparam int unsigned DMI_OP_MSB   = 1;
  localparam int unsigned DMI_OP_LSB   = 0;

  typedef enum logic [1:0] {
    DMI_NOP   = 2'd0,
    DMI_READ  = 2'd1,
    DMI_WRITE = 2'd2,
    DMI_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    DBUS_OK   = 2'd0,
    DBUS_FAIL = 2'd2,
    DBUS_BUSY = 2'd3
  } dbus_stat_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } dtm_fsm_e;

  typedef struct packed {
    logic [DMI_ADDR_W-1:0] addr;
    logic [DMI_DATA_W-1:0] data;
    logic [1:0]            op;
  } dmi_req_t;

endpackage

// File: rtl/riscv_dtm_dbus_ctrl.sv
// DTM-side DMI initiator: turns dbus update-DR scans into DMI requests and tracks dbusstat.
// Optional response timeout enabled by defining RISCV_DTM_TIMEOUT_EN.
module riscv_dtm_dbus_ctrl
  import riscv_dbg_pkg::*;
#(
  parameter int unsigned ABITS      = 5,
  parameter int unsigned TMO_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  upd_vld,
  input  logic [DMI_W-1:0]      upd_bits,
  input  logic                  dbusreset,
  output logic [DMI_W-1:0]      cap_bits,
  output logic [1:0]            dbusstat,
  output logic                  busy,
  output logic                  dtm_req_valid,
  input  logic                  dtm_req_ready,
  output logic [DMI_W-1:0]      dtm_req_bits,
  input  logic                  dtm_resp_valid,
  output logic                  dtm_resp_ready,
  input  logic [DMI_RESP_W-1:0] dtm_resp_bits
);

  if (ABITS != DMI_ADDR_W || TMO_CYCLES < 2) begin : g_param_chk
    $error("riscv_dtm_dbus_ctrl: ABITS must be 5 and TMO_CYCLES >= 2");
  end

  dtm_fsm_e              state_q, state_d;
  logic [1:0]            sticky_q, sticky_d;
  logic [DMI_ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [DMI_DATA_W-1:0] last_rdata_q, last_rdata_d;
  dmi_req_t              req_q, req_d;
  logic [1:0]            stat_d;
  dmi_op_e               upd_op;
  logic                  tmo_q, tmo_d;

`ifdef RISCV_DTM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign upd_op = dmi_op_e'(upd_bits[DMI_OP_MSB:DMI_OP_LSB]);

  // Next-state, sticky status and capture-register updates.
  always_comb begin
    state_d      = state_q;
    sticky_d     = dbusreset ? 2'(DBUS_OK) : sticky_q;
    last_addr_d  = last_addr_q;
    last_rdata_d = last_rdata_q;
    req_d        = req_q;
    tmo_d        = tmo_q;
`ifdef RISCV_DTM_TIMEOUT_EN
    cnt_d        = '0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        tmo_d = 1'b0;
        if (upd_vld && (sticky_d == 2'(DBUS_OK)) &&
            ((upd_op == DMI_READ) || (upd_op == DMI_WRITE))) begin
          state_d     = ST_REQ;
          req_d       = dmi_req_t'(upd_bits);
          last_addr_d = upd_bits[DMI_ADDR_MSB:DMI_ADDR_LSB];
        end
      end
      ST_REQ: begin
        tmo_d = 1'b0;
        if (dtm_req_ready) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (dtm_resp_valid) begin
          state_d = ST_IDLE;
          // A response that arrives after a timeout is drained without effect.
          if (!tmo_q) begin
            last_rdata_d = dtm_resp_bits[DMI_DATA_MSB:DMI_DATA_LSB];
            if (dtm_resp_bits[1:0] != 2'b00) sticky_d = 2'(DBUS_FAIL);
          end
        end
`ifdef RISCV_DTM_TIMEOUT_EN
        else if (!tmo_q) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(TMO_CYCLES - 1)) begin
            sticky_d = 2'(DBUS_FAIL);
            tmo_d    = 1'b1;
          end
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Any scan while a transaction is outstanding is a busy violation.
    if (upd_vld && (state_q != ST_IDLE)) sticky_d = 2'(DBUS_BUSY);

    if (sticky_d != 2'(DBUS_OK))  stat_d = sticky_d;
    else if (state_d != ST_IDLE)  stat_d = 2'(DBUS_BUSY);
    else                          stat_d = 2'(DBUS_OK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      sticky_q       <= '0;
      last_addr_q    <= '0;
      last_rdata_q   <= '0;
      req_q          <= '0;
      tmo_q          <= 1'b0;
      busy           <= 1'b0;
      dbusstat       <= '0;
      cap_bits       <= '0;
      dtm_req_valid  <= 1'b0;
      dtm_resp_ready <= 1'b0;
      dtm_req_bits   <= '0;
    end else begin
      state_q        <= state_d;
      sticky_q       <= sticky_d;
      last_addr_q    <= last_addr_d;
      last_rdata_q   <= last_rdata_d;
      req_q          <= req_d;
      tmo_q          <= tmo_d;
      busy           <= (state_d != ST_IDLE);
      dbusstat       <= stat_d;
      cap_bits       <= {last_addr_d, last_rdata_d, stat_d};
      dtm_req_valid  <= (state_d == ST_REQ);
      dtm_resp_ready <= (state_d == ST_RSP);
      dtm_req_bits   <= req_d;
    end
  end

`ifdef RISCV_DTM_TIMEOUT_EN
  // Response timeout counter; restarts from zero on every entry to RSP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_riscv_dtm_dbus_ctrl.sv
// Directed self-checking bench for riscv_dtm_dbus_ctrl (timeout section only with RISCV_DTM_TIMEOUT_EN).
module tb_riscv_dtm_dbus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_vld;
  logic [40:0] upd_bits;
  logic        dbusreset;
  logic [40:0] cap_bits;
  logic [1:0]  dbusstat;
  logic        busy;
  logic        dtm_req_valid;
  logic        dtm_req_ready;
  logic [40:0] dtm_req_bits;
  logic        dtm_resp_valid;
  logic        dtm_resp_ready;
  logic [35:0] dtm_resp_bits;

  int total = 0;
  int bad   = 0;
  int req_cnt = 0;
  int base;

  always #5 clk = ~clk;

  riscv_dtm_dbus_ctrl #(.ABITS(5), .TMO_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_vld(upd_vld), .upd_bits(upd_bits), .dbusreset(dbusreset),
    .cap_bits(cap_bits), .dbusstat(dbusstat), .busy(busy),
    .dtm_req_valid(dtm_req_valid), .dtm_req_ready(dtm_req_ready), .dtm_req_bits(dtm_req_bits),
    .dtm_resp_valid(dtm_resp_valid), .dtm_resp_ready(dtm_resp_ready), .dtm_resp_bits(dtm_resp_bits)
  );

  always @(posedge clk) if (rst_n && dtm_req_valid && dtm_req_ready) req_cnt <= req_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [1:0] op, input logic [4:0] a, input logic [33:0] d);
    upd_vld  = 1'b1;
    upd_bits = {a, d, op};
    tick();
    upd_vld  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    chk(tag, 64'(busy), 64'd0);
  endtask

  function automatic logic [40:0] cap(input logic [4:0] a, input logic [33:0] d, input logic [1:0] s);
    return {a, d, s};
  endfunction

  initial begin
    rst_n = 1'b0; upd_vld = 1'b0; upd_bits = '0; dbusreset = 1'b0;
    dtm_req_ready = 1'b1; dtm_resp_valid = 1'b1; dtm_resp_bits = '0;
    repeat (3) tick();
    chk("rst_req_valid", 64'(dtm_req_valid), 64'd0);
    chk("rst_resp_ready", 64'(dtm_resp_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stat", 64'(dbusstat), 64'd0);
    chk("rst_cap", 64'(cap_bits), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: write with ready/valid tied high
    dtm_resp_bits = {34'h3_0000_0004, 2'b00};
    upd(2'd2, 5'h10, 34'h3_0000_0004);
    chk("t1_req_valid", 64'(dtm_req_valid), 64'd1);
    chk("t1_req_bits", 64'(dtm_req_bits), 64'({5'h10, 34'h3_0000_0004, 2'd2}));
    chk("t1_stat_live", 64'(dbusstat), 64'd3);
    tick();
    chk("t1_resp_ready", 64'(dtm_resp_ready), 64'd1);
    chk("t1_busy_c2", 64'(busy), 64'd1);
    tick();
    chk("t1_busy_c3", 64'(busy), 64'd0);
    chk("t1_cap", 64'(cap_bits), 64'(cap(5'h10, 34'h3_0000_0004, 2'd0)));
    chk("t1_nreq", 64'(req_cnt), 64'd1);

    // 2: read with 5-cycle stall on req_ready
    dtm_req_ready = 1'b0;
    dtm_resp_bits = {34'h0_DEAD_BEEF, 2'b00};
    upd(2'd1, 5'h00, 34'h0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_valid", 64'(dtm_req_valid), 64'd1);
      chk("t2_stall_bits", 64'(dtm_req_bits), 64'({5'h00, 34'h0, 2'd1}));
      if (i < 4) tick();
    end
    dtm_req_ready = 1'b1;
    wait_idle("t2_idle", 20);
    chk("t2_cap", 64'(cap_bits), 64'(cap(5'h00, 34'h0_DEAD_BEEF, 2'd0)));

    // 3: second update during RSP is a busy violation
    base = req_cnt;
    dtm_resp_valid = 1'b0;
    dtm_resp_bits = {34'h1234, 2'b00};
    upd(2'd2, 5'h01, 34'h55AA);
    tick();
    chk("t3_in_rsp", 64'(dtm_resp_ready), 64'd1);
    upd(2'd1, 5'h02, 34'h0);
    dtm_resp_valid = 1'b1;
    wait_idle("t3_idle", 20);
    chk("t3_one_req", 64'(req_cnt - base), 64'd1);
    chk("t3_stat_sticky", 64'(dbusstat), 64'd3);
    upd(2'd1, 5'h03, 34'h0);
    tick(); tick();
    chk("t3_dropped", 64'(req_cnt - base), 64'd1);
    chk("t3_cap_sticky", 64'(cap_bits), 64'(cap(5'h01, 34'h1234, 2'd3)));
    dbusreset = 1'b1; tick(); dbusreset = 1'b0;
    chk("t3_stat_clr", 64'(dbusstat), 64'd0);
    upd(2'd1, 5'h04, 34'h0);
    wait_idle("t3_idle2", 20);
    chk("t3_reissue", 64'(req_cnt - base), 64'd2);
    chk("t3_cap2", 64'(cap_bits), 64'(cap(5'h04, 34'h1234, 2'd0)));

    // 4: nop while idle is ignored
    base = req_cnt;
    upd(2'd0, 5'h1F, 34'h3_FFFF_FFFF);
    chk("t4_nop_valid", 64'(dtm_req_valid), 64'd0);
    chk("t4_nop_busy", 64'(busy), 64'd0);
    tick();
    chk("t4_nop_cap", 64'(cap_bits), 64'(cap(5'h04, 34'h1234, 2'd0)));
    chk("t4_nop_nreq", 64'(req_cnt - base), 64'd0);
    // create sticky=3, then dbusreset together with a read
    dtm_resp_valid = 1'b0;
    upd(2'd2, 5'h05, 34'h1);
    tick();
    upd(2'd2, 5'h06, 34'h2);
    dtm_resp_valid = 1'b1;
    wait_idle("t4_idle", 20);
    chk("t4_sticky3", 64'(dbusstat), 64'd3);
    base = req_cnt;
    dbusreset = 1'b1;
    upd(2'd1, 5'h08, 34'h0);
    dbusreset = 1'b0;
    chk("t4_rst_upd_valid", 64'(dtm_req_valid), 64'd1);
    chk("t4_rst_upd_bits", 64'(dtm_req_bits), 64'({5'h08, 34'h0, 2'd1}));
    wait_idle("t4_idle2", 20);
    chk("t4_stat_ok", 64'(dbusstat), 64'd0);
    chk("t4_issued", 64'(req_cnt - base), 64'd1);

    // 5: error response sets sticky fail
    dtm_resp_bits = {34'h55, 2'd2};
    upd(2'd1, 5'h07, 34'h0);
    wait_idle("t5_idle", 20);
    chk("t5_stat_fail", 64'(dbusstat), 64'd2);
    chk("t5_cap", 64'(cap_bits), 64'(cap(5'h07, 34'h55, 2'd2)));
    base = req_cnt;
    upd(2'd1, 5'h09, 34'h0);
    tick();
    chk("t5_dropped", 64'(req_cnt - base), 64'd0);
    chk("t5_still_fail", 64'(dbusstat), 64'd2);
    dbusreset = 1'b1; tick(); dbusreset = 1'b0;
    chk("t5_clr", 64'(dbusstat), 64'd0);

`ifdef RISCV_DTM_TIMEOUT_EN
    // 6: response withheld past the timeout
    dtm_resp_valid = 1'b0;
    dtm_resp_bits = {34'h3_0BAD_0BAD, 2'b00};
    upd(2'd1, 5'h0A, 34'h0);
    tick();
    chk("t6_in_rsp", 64'(dtm_resp_ready), 64'd1);
    repeat (15) tick();
    chk("t6_pre_tmo", 64'(dbusstat), 64'd3);
    tick();
    chk("t6_tmo_stat", 64'(dbusstat), 64'd2);
    chk("t6_still_rsp", 64'(dtm_resp_ready), 64'd1);
    repeat (24) tick();
    dtm_resp_valid = 1'b1;
    wait_idle("t6_drain", 5);
    chk("t6_cap", 64'(cap_bits), 64'(cap(5'h0A, 34'h55, 2'd2)));
    dbusreset = 1'b1; tick(); dbusreset = 1'b0;
`endif

    // reset asserted mid-REQ
    dtm_req_ready = 1'b0;
    upd(2'd2, 5'h0B, 34'h7);
    chk("rq_valid_pre", 64'(dtm_req_valid), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rq_valid", 64'(dtm_req_valid), 64'd0);
    chk("rq_busy", 64'(busy), 64'd0);
    chk("rq_stat", 64'(dbusstat), 64'd0);
    chk("rq_cap", 64'(cap_bits), 64'd0);
    chk("rq_bits", 64'(dtm_req_bits), 64'd0);
    chk("rq_resp_ready", 64'(dtm_resp_ready), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
